// File: rtl/mux_sel_arb.sv
// mux_sel_arb: two-requester round-robin arbiter driving a registered 2:1 mux select with burst limit.
// Optional ARB_FIXED_PRI_EN: fixed A-over-B priority, no burst limit.
module mux_sel_arb #(
  parameter int BURST = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_A,
  input  logic REQ_B,
  output logic GNT_A,
  output logic GNT_B,
  output logic SEL,
  output logic SWITCH,
  output logic BUSY
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  state_t state, nxt;
  logic [7:0] cnt, cnt_nxt;
  logic last, last_nxt;
  logic sel_nxt;
`ifdef ARB_FIXED_PRI_EN
  always_comb begin
    nxt = REQ_A ? GRANT_A : REQ_B ? GRANT_B : IDLE;
    cnt_nxt = cnt;
    last_nxt = last;
    sel_nxt = nxt == GRANT_A ? 1'b0 : nxt == GRANT_B ? 1'b1 : SEL;
  end
`else
  logic wrap, enter;
  assign wrap = cnt == 8'(BURST - 1);
  // last: 0 = A served last, 1 = B served last
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = (REQ_A && REQ_B) ? (last ? GRANT_A : GRANT_B) :
                     REQ_A ? GRANT_A : REQ_B ? GRANT_B : IDLE;
      GRANT_A: nxt = !REQ_A ? (REQ_B ? GRANT_B : IDLE) : (REQ_B && wrap) ? GRANT_B : GRANT_A;
      GRANT_B: nxt = !REQ_B ? (REQ_A ? GRANT_A : IDLE) : (REQ_A && wrap) ? GRANT_A : GRANT_B;
      default: nxt = IDLE;
    endcase
    enter = nxt != state && nxt != IDLE;
    cnt_nxt = enter ? 8'd0 : nxt == IDLE ? cnt : wrap ? 8'd0 : cnt + 8'd1;
    last_nxt = enter ? (nxt == GRANT_B) : last;
    sel_nxt = nxt == GRANT_A ? 1'b0 : nxt == GRANT_B ? 1'b1 : SEL;
  end
`endif
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      GNT_A  <= 1'b0;
      GNT_B  <= 1'b0;
      SEL    <= 1'b0;
      SWITCH <= 1'b0;
      BUSY   <= 1'b0;
      cnt    <= 8'd0;
      last   <= 1'b1;
    end else begin
      state  <= nxt;
      GNT_A  <= nxt == GRANT_A;
      GNT_B  <= nxt == GRANT_B;
      SEL    <= sel_nxt;
      SWITCH <= sel_nxt != SEL;
      BUSY   <= nxt != IDLE;
      cnt    <= cnt_nxt;
      last   <= last_nxt;
    end
  end
endmodule

// File: tb/tb_mux_sel_arb.sv
// tb_mux_sel_arb: directed self-checking bench for mux_sel_arb (BURST=4 and BURST=1 instances).
module tb_mux_sel_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0, req_a1 = 1'b0, req_b1 = 1'b0;
  logic gnt_a, gnt_b, sel, switch_o, busy;
  logic gnt_a1, gnt_b1, sel1, switch1, busy1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mux_sel_arb #(.BURST(4)) dut (
    .CLK(clk), .RST(rst), .REQ_A(req_a), .REQ_B(req_b),
    .GNT_A(gnt_a), .GNT_B(gnt_b), .SEL(sel), .SWITCH(switch_o), .BUSY(busy)
  );

  mux_sel_arb #(.BURST(1)) dut1 (
    .CLK(clk), .RST(rst), .REQ_A(req_a1), .REQ_B(req_b1),
    .GNT_A(gnt_a1), .GNT_B(gnt_b1), .SEL(sel1), .SWITCH(switch1), .BUSY(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_a = 0; req_b = 0; req_a1 = 0; req_b1 = 0;
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({gnt_a, gnt_b, sel, switch_o, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b want 00000", {gnt_a, gnt_b, sel, switch_o, busy});
    end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({gnt_a, gnt_b, sel, switch_o, busy} !== 5'b0) begin
        errors++;
        $display("FAIL idle_%0d: got %b want 00000", i, {gnt_a, gnt_b, sel, switch_o, busy});
      end
    end
  endtask

  task automatic test_single_a();
    req_a = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({gnt_a, gnt_b, sel, switch_o, busy} !== 5'b10001) begin
        errors++;
        $display("FAIL single_a_%0d: got %b want 10001", i, {gnt_a, gnt_b, sel, switch_o, busy});
      end
    end
    req_a = 0;
    step();
    checks++;
    if ({gnt_a, gnt_b, sel, switch_o, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL single_a_drop: got %b want 00000", {gnt_a, gnt_b, sel, switch_o, busy});
    end
  endtask

  task automatic test_burst();
    logic exp_a, exp_sw;
    do_reset();
    req_a = 1; req_b = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_a = ((i / 4) % 2) == 0;
      exp_sw = (i == 4) || (i == 8);
      checks++;
      if ({gnt_a, gnt_b, sel, switch_o, busy} !== {exp_a, !exp_a, !exp_a, exp_sw, 1'b1}) begin
        errors++;
        $display("FAIL burst_%0d: got %b want %b", i, {gnt_a, gnt_b, sel, switch_o, busy},
                 {exp_a, !exp_a, !exp_a, exp_sw, 1'b1});
      end
    end
    req_a = 0; req_b = 0;
    step();
    checks++;
    if ({gnt_a, gnt_b, sel, switch_o, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL burst_idle: got %b want 00000", {gnt_a, gnt_b, sel, switch_o, busy});
    end
  endtask

  task automatic test_burst1();
    logic exp_a;
    do_reset();
    req_a1 = 1; req_b1 = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_a = (i % 2) == 0;
      checks++;
      if ({gnt_a1, gnt_b1, sel1, switch1, busy1} !== {exp_a, !exp_a, !exp_a, i != 0, 1'b1}) begin
        errors++;
        $display("FAIL burst1_%0d: got %b want %b", i, {gnt_a1, gnt_b1, sel1, switch1, busy1},
                 {exp_a, !exp_a, !exp_a, i != 0, 1'b1});
      end
    end
    req_a1 = 0; req_b1 = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_b = 1;
    step();
    checks++;
    if ({gnt_a, gnt_b, sel, busy} !== 4'b0111) begin
      errors++;
      $display("FAIL grant_b: got %b want 0111", {gnt_a, gnt_b, sel, busy});
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({gnt_b, sel, busy, switch_o} !== 4'b0000) begin
      errors++;
      $display("FAIL async_rst: got %b want 0000", {gnt_b, sel, busy, switch_o});
    end
    req_a = 1; req_b = 1;
    #1 rst = 0;
    step();
    checks++;
    if ({gnt_a, gnt_b, sel, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL rst_restart: got %b want 1001", {gnt_a, gnt_b, sel, busy});
    end
    req_a = 0; req_b = 0;
  endtask

  task automatic test_fixed_pri();
    do_reset();
    req_a = 1; req_b = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({gnt_a, gnt_b, sel, switch_o} !== 4'b1000) begin
        errors++;
        $display("FAIL fixed_%0d: got %b want 1000", i, {gnt_a, gnt_b, sel, switch_o});
      end
    end
    req_a = 0;
    step();
    checks++;
    if ({gnt_a, gnt_b, sel, switch_o} !== 4'b0111) begin
      errors++;
      $display("FAIL fixed_handoff: got %b want 0111", {gnt_a, gnt_b, sel, switch_o});
    end
    step();
    checks++;
    if ({gnt_a, gnt_b, sel, switch_o} !== 4'b0110) begin
      errors++;
      $display("FAIL fixed_hold_b: got %b want 0110", {gnt_a, gnt_b, sel, switch_o});
    end
    req_a = 1;
    step();
    checks++;
    if ({gnt_a, gnt_b, sel, switch_o} !== 4'b1001) begin
      errors++;
      $display("FAIL fixed_preempt: got %b want 1001", {gnt_a, gnt_b, sel, switch_o});
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
`ifdef ARB_FIXED_PRI_EN
    test_fixed_pri();
`else
    test_burst();
    test_burst1();
    test_async_reset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  always @(negedge clk) begin
    if (!rst && ((gnt_a && gnt_b) || (gnt_a1 && gnt_b1))) begin
      errors++;
      $display("FAIL both_grants: got a=%b b=%b a1=%b b1=%b want never both", gnt_a, gnt_b, gnt_a1, gnt_b1);
    end
  end
endmodule
